// File: rtl/seg_pkg.sv
// seg_pkg
//   Shared constants for the seven-segment scan driver.
//   seg_font : active-high {g,f,e,d,c,b,a} pattern for each hex nibble 0..F.
//   seg_off  : active-high pattern of a dark digit.
package seg_pkg;

  localparam logic [6:0] seg_font [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] seg_off = 7'h00;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode
//   Purely combinational hex nibble to seven-segment decoder (active-high).
//   Ports:
//     nibble : 4-bit hex digit
//     seg    : {g,f,e,d,c,b,a} pattern, 1 = segment lit
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = seg_font[nibble];

endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan
//   Time-multiplexed seven-segment display driver. A shadow register captures
//   the hex value and decimal points; the digits are scanned one per slot of
//   CLK_DIV clocks, with leading-zero blanking, whole-display blinking and a
//   frame pulse. All outputs are registered and update on the slot tick.
//   Ports:
//     clk      : system clock, rising edge
//     rst      : asynchronous, active-low reset
//     value    : hex value, nibble i drives digit i (bits above 4*NUM_DIGITS ignored)
//     load     : single-cycle strobe; value/dp_in are captured on the clock edge
//                where load=1. There is no back-pressure: every strobe is taken.
//     blank_lz : enable leading-zero blanking
//     blink_en : enable whole-display blinking
//     dp_in    : decimal point per digit
//     seg_o    : segments {g,f,e,d,c,b,a} of the active digit
//     dp_o     : decimal point of the active digit
//     an_o     : one-hot digit enable
//     frame_o  : one-cycle pulse once digit NUM_DIGITS-1 has finished its slot
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int DATA_W         = 32,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  frame_o
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W  = $clog2(CLK_DIV);
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int VAL_W  = 4 * NUM_DIGITS;

  // Pin polarity: XOR masks turn active-high internal values into pin levels.
  localparam logic pol = SEG_ACTIVE_LOW;

  logic [VAL_W-1:0]      shadow_val;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [BCNT_W-1:0]     bcnt;
  logic                  phase;
  logic                  scanning;  // set once the first digit has been driven
  logic                  tick;
  logic                  last_digit;
  logic                  wrap;

  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic                  blank;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS:0]   zero_from;  // zero_from[k]: nibbles k..NUM_DIGITS-1 all zero
  logic [6:0]            next_seg;
  logic                  next_dp;
  logic [NUM_DIGITS-1:0] next_an;

  generate
    if (DATA_W > VAL_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^value[DATA_W-1:VAL_W];
    end
  endgenerate

  assign tick       = (pre == PRE_W'(CLK_DIV - 1));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = tick && last_digit;

  // Shadow registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value[VAL_W-1:0];
      shadow_dp  <= dp_in;
    end
  end

  // Prescaler and digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre      <= '0;
      idx      <= '0;
      scanning <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx      <= last_digit ? '0 : idx + 1'b1;
        scanning <= 1'b1;
      end
    end
  end

  // Blink frame counter; phase flips on the frame wrap so it lines up with digit 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (!blink_en) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  // Digit select, leading-zero detection and per-digit mux
  always_comb begin
    nib       = 4'h0;
    blank     = 1'b0;
    dp_sel    = 1'b0;
    an_sel    = '0;
    zero_from = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (shadow_val[4*k +: 4] == 4'h0);
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        nib       = shadow_val[4*k +: 4];
        dp_sel    = shadow_dp[k];
        an_sel[k] = 1'b1;
        // Digit 0 always shows, so a zero value still reads "0".
        blank     = blank_lz && (k != 0) && zero_from[k];
      end
    end
  end

  seg_hex_decode u_decode (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    next_seg = blank ? seg_off : dec_seg;
    next_dp  = blank ? 1'b0 : dp_sel;
    // Blanked digits keep their anode; only blinking darkens anodes.
    next_an  = (blink_en && phase) ? '0 : an_sel;
  end

  // Output registers: load on the tick, so digit idx shows one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_o <= seg_off ^ {7{pol}};
      dp_o  <= pol;
      an_o  <= {NUM_DIGITS{pol}};
    end else if (tick) begin
      seg_o <= next_seg ^ {7{pol}};
      dp_o  <= next_dp ^ pol;
      an_o  <= next_an ^ {NUM_DIGITS{pol}};
    end
  end

  // Frame pulse accompanies the digit-0 outputs of every frame after the first,
  // i.e. it marks the end of digit NUM_DIGITS-1's slot on the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_o <= 1'b0;
    end else begin
      frame_o <= tick && (idx == '0) && scanning;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan
//   Directed bench for seg_display_scan with NUM_DIGITS=6, CLK_DIV=4,
//   BLINK_FRAMES=2, active-low pins. Expected per-slot outputs are queued
//   with their slot number; a monitor compares them at each slot boundary.
module tb_seg_display_scan;

  localparam int ND = 6;
  localparam int DW = 32;
  localparam int CD = 4;
  localparam int BF = 2;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] value = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic          blink_en = 1'b0;
  logic [ND-1:0] dp_in = '0;
  logic [6:0]    seg_o;
  logic          dp_o;
  logic [ND-1:0] an_o;
  logic          frame_o;

  always #5 clk = ~clk;

  seg_display_scan #(
    .NUM_DIGITS     (ND),
    .DATA_W         (DW),
    .CLK_DIV        (CD),
    .BLINK_FRAMES   (BF),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .dp_in    (dp_in),
    .seg_o    (seg_o),
    .dp_o     (dp_o),
    .an_o     (an_o),
    .frame_o  (frame_o)
  );

  // Scoreboard state
  int          errors = 0;
  int          checks = 0;
  int          cyc;
  logic [14:0] exp_q[$];   // {frame, an[5:0], seg[6:0], dp}
  int          slot_q[$];

  logic [6:0] font_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  // Hand-computed pin levels for 0x..123456: digit d shows nibble 6-d, inverted.
  logic [6:0] seg_123456 [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [5:0] an_one     [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  // Cycles since reset release; slot s ends its first cycle at cyc == 4*s.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    int s;
    logic [14:0] e;
    if (rst === 1'b1 && cyc > 0) begin
      if (cyc % CD == 0) begin
        s = cyc / CD;
        while (slot_q.size() > 0 && slot_q[0] < s) begin
          checks++;
          errors++;
          $display("FAIL slot_%0d: expectation was skipped", slot_q[0]);
          void'(slot_q.pop_front());
          void'(exp_q.pop_front());
        end
        if (slot_q.size() > 0 && slot_q[0] == s) begin
          e = exp_q.pop_front();
          void'(slot_q.pop_front());
          check($sformatf("slot%0d_frame", s), 32'(frame_o), 32'(e[14]));
          check($sformatf("slot%0d_an", s),    32'(an_o),    32'(e[13:8]));
          check($sformatf("slot%0d_seg", s),   32'(seg_o),   32'(e[7:1]));
          check($sformatf("slot%0d_dp", s),    32'(dp_o),    32'(e[0]));
        end
      end else begin
        check($sformatf("frame_idle_cyc%0d", cyc), 32'(frame_o), 32'd0);
      end
    end
  end

  // Driver tasks
  task automatic push(input int s, input logic fr, input logic [5:0] an,
                      input logic [6:0] seg, input logic dp);
    exp_q.push_back({fr, an, seg, dp});
    slot_q.push_back(s);
  endtask

  // Reference for a slot: digit (s-1)%6, frame pulse from slot 7 on digit 0.
  task automatic push_model(input int s, input logic [31:0] v, input logic [5:0] dp,
                            input logic blz, input logic dark);
    int d;
    logic [3:0] nib;
    logic blank;
    logic [6:0] seg_h;
    logic dp_h;
    logic [5:0] an_h;
    d     = (s - 1) % ND;
    nib   = v[4*d +: 4];
    blank = blz && (d != 0) && ((v[23:0] >> (4*d)) == 24'h0);
    seg_h = blank ? 7'h00 : font_t[nib];
    dp_h  = blank ? 1'b0 : dp[d];
    an_h  = dark ? 6'h00 : (6'b1 << d);
    push(s, (s >= 7) && (d == 0), ~an_h, ~seg_h, ~dp_h);
  endtask

  task automatic wait_cyc(input int c);
    int n;
    n = 0;
    while (!(rst === 1'b1 && cyc == c) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc%0d: timed out at cyc %0d", c, cyc);
    end
  endtask

  task automatic wait_slot(input int s);
    wait_cyc(CD * s);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [5:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"},    32'(an_o),    32'h3F);
    check({tag, "_seg"},   32'(seg_o),   32'h7F);
    check({tag, "_dp"},    32'(dp_o),    32'd1);
    check({tag, "_frame"}, 32'(frame_o), 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i < CD; i++) begin
      @(negedge clk);
      check_reset_pins($sformatf("pretick%0d", i));
    end
  endtask

  // Stimulus
  initial begin
    int d;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");

    // First digit after release: shadow is 0, digit 0 shows "0".
    push_model(1, 32'h0, 6'h0, 1'b0, 1'b0);
    release_rst();

    // Plain scan of 0x00123456, two full frames.
    wait_slot(1);
    do_load(32'h00123456, 6'h00);
    for (int s = 2; s <= 13; s++) begin
      d = (s - 1) % ND;
      push(s, (s >= 7) && (d == 0), an_one[d], seg_123456[d], 1'b1);
    end

    // Leading-zero blanking: digits 4 and 5 dark, anodes still driven.
    wait_slot(13);
    blank_lz = 1'b1;
    do_load(32'h00003456, 6'h00);
    for (int s = 14; s <= 19; s++) push_model(s, 32'h00003456, 6'h00, 1'b1, 1'b0);

    // Zero value with blanking: only digit 0 lit, as "0".
    wait_slot(19);
    do_load(32'h0, 6'h00);
    for (int s = 20; s <= 25; s++) begin
      d = (s - 1) % ND;
      push(s, (d == 0), an_one[d], (d == 0) ? 7'h40 : 7'h7F, 1'b1);
    end

    // Embedded zeros below a non-zero digit are not blanked.
    wait_slot(25);
    do_load(32'h00100456, 6'h00);
    for (int s = 26; s <= 31; s++) push_model(s, 32'h00100456, 6'h00, 1'b1, 1'b0);

    // Decimal point on digit 2 only.
    wait_slot(31);
    blank_lz = 1'b0;
    do_load(32'h00123456, 6'b000100);
    for (int s = 32; s <= 37; s++) begin
      d = (s - 1) % ND;
      push(s, (d == 0), an_one[d], seg_123456[d], (d == 2) ? 1'b0 : 1'b1);
    end

    // Load on the tick edge: slot 37 keeps the old value, slot 38 the new one.
    wait_cyc(CD * 37 - 1);
    do_load(32'hFFABCDEF, 6'h00);
    for (int s = 38; s <= 43; s++) push_model(s, 32'hFFABCDEF, 6'h00, 1'b0, 1'b0);

    // Blink: lit slots 43..54, dark 55..66, lit 67..78.
    wait_slot(43);
    blink_en = 1'b1;
    for (int s = 44; s <= 78; s++)
      push_model(s, 32'hFFABCDEF, 6'h00, 1'b0, (s >= 55) && (s <= 66));

    wait_slot(78);
    blink_en = 1'b0;
    for (int s = 79; s <= 84; s++) push_model(s, 32'hFFABCDEF, 6'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-slot; shadow must read back as 0.
    wait_slot(84);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_pins("midslot_rst");
    check("midslot_queue_empty", 32'(exp_q.size()), 32'd0);
    push_model(1, 32'h0, 6'h0, 1'b0, 1'b0);
    push_model(2, 32'h0, 6'h0, 1'b0, 1'b0);
    release_rst();

    // Reset while a load is being presented.
    wait_slot(2);
    @(negedge clk);
    #1;
    value = 32'h12345678;
    dp_in = 6'h3F;
    load  = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_reset_pins("load_rst");
    load = 1'b0;
    push_model(1, 32'h0, 6'h0, 1'b0, 1'b0);
    push_model(2, 32'h0, 6'h0, 1'b0, 1'b0);
    release_rst();

    wait_slot(3);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
